// File: rtl/sipo_rx.sv
// sipo_rx: serial-in/parallel-out receiver. Collects MSB-first words aligned
// by sof, hands each finished word to a one-entry valid/ready buffer, and
// flags dropped words (sticky overrun) and discarded partial words (abort).
module sipo_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             SI,
    input  logic             sof,
    output logic [WIDTH-1:0] PO,
    output logic             po_valid,
    input  logic             po_ready,
    output logic             overrun,
    output logic             abort,
    input  logic             ovr_clr
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sh;

    logic             w_done;
    logic [WIDTH-1:0] w_word;
    logic             w_take;
    logic             w_ovr_set;

    // The last bit completes a word in the same edge it is sampled.
    assign w_done    = en && !sof && (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));
    assign w_word    = {r_sh[WIDTH-2:0], SI};
    // Buffer can accept when empty, or when the current word leaves this edge.
    assign w_take    = !po_valid || po_ready;
    assign w_ovr_set = w_done && !w_take;

    // Word assembly FSM plus output buffer, abort pulse and sticky overrun.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_sh     <= '0;
            PO       <= '0;
            po_valid <= 1'b0;
            overrun  <= 1'b0;
            abort    <= 1'b0;
        end else begin
            abort <= 1'b0;

            if (en) begin
                if (sof) begin
                    // New MSB; any partial word in flight is thrown away.
                    abort   <= (r_state == SHIFT);
                    r_sh    <= {{(WIDTH-1){1'b0}}, SI};
                    r_cnt   <= CW'(1);
                    r_state <= SHIFT;
                end else if (r_state == SHIFT) begin
                    r_sh <= w_word;
                    if (w_done) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                // IDLE without sof: bits ahead of the first marker are dropped.
            end

            if (w_done) begin
                if (w_take) begin
                    PO       <= w_word;
                    po_valid <= 1'b1;
                end
            end else if (po_valid && po_ready) begin
                po_valid <= 1'b0;
            end

            // A fresh overrun beats a simultaneous clear.
            if (w_ovr_set)
                overrun <= 1'b1;
            else if (ovr_clr)
                overrun <= 1'b0;
        end
    end

endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in/parallel-out receiver that sits directly downstream of the 4-bit PISO serializer. It samples the serial stream MSB-first, reassembles WIDTH-bit words aligned by a start marker, and presents each word on a one-entry output buffer with a valid/ready handshake. Overrun and framing-abort conditions are flagged so the consumer can detect lost data.

## Interface
- WIDTH, 4, word width in bits; must be ≥2; matches the serializer's parallel width
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (rst=0 at a rising edge resets the block)
- en  in  1  serial bit valid; SI is sampled only on edges where en=1
- SI  in  1  serial data, MSB of each word first
- sof  in  1  start-of-frame; qualified by en; marks the current SI as the MSB of a new word
- PO  out  WIDTH  output word buffer
- po_valid  out  1  PO holds an unconsumed word
- po_ready  in  1  consumer accepts PO on an edge where po_valid=1 and po_ready=1
- overrun  out  1  sticky: a completed word was dropped because the buffer was full
- abort  out  1  one-cycle pulse: a partial word was discarded by a new sof
- ovr_clr  in  1  clears overrun on the next edge

## Operation
- States: IDLE (no bits collected), SHIFT (1..WIDTH-1 bits collected).
- IDLE: en=1 and sof=1 → shift reg ← {.., SI}, bit count = 1, go SHIFT. en=1 with sof=0 is ignored (bits before the first sof are discarded). WIDTH=1 is not supported.
- SHIFT, en=1, sof=0: shift left, SI into LSB, count+1. When count reaches WIDTH, the word is complete: go IDLE, count=0, attempt load into PO.
- SHIFT, en=1, sof=1: discard the partial word, pulse abort next cycle, treat SI as the MSB of a new word (count=1, stay SHIFT).
- en=0: hold state, count, and shift register; no side effects.
- Word load: if po_valid=0, or po_valid=1 and po_ready=1 on the same edge, PO ← assembled word and po_valid=1. Otherwise the new word is dropped, PO is unchanged, and overrun is set.
- Consume: po_valid=1 and po_ready=1 with no word completing → po_valid=0. PO retains its last value.
- overrun clears only on ovr_clr=1 or reset. If ovr_clr=1 and a new overrun occur on the same edge, set wins (overrun=1).
- Bit order: the first bit received is PO[WIDTH-1] and the last is PO[0], so a PISO loaded with PI reproduces PI on PO.

## Timing
- Reset values: PO=0, po_valid=0, overrun=0, abort=0; state=IDLE, count=0, shift register=0.
- Reset mid-word discards the partial word and any buffered PO word, with no abort pulse. Reset overrides all other inputs.
- Latency: the WIDTH-th bit is sampled at edge N; PO and po_valid update at edge N, visible in cycle N+1. With back-to-back en there are no idle cycles between words.
- abort is high for exactly one cycle, after the edge that sampled the interrupting sof.
- po_ready is ignored while po_valid=0. PO is stable while po_valid=1 and not yet accepted.
- Throughput: one word per WIDTH enabled bits; the buffer sustains full rate if po_ready is held high.

## Test plan
- Reset: drive rst=0 for 2 cycles with random SI/en/sof → PO=0, po_valid=0, overrun=0, abort=0.
- Single word: sof+en with SI=1, then SI=0,1,1 on consecutive en cycles; po_ready=0 → PO=4'b1011 and po_valid=1 in the cycle after the 4th bit. Then po_ready=1 for one cycle → po_valid=0 and PO stays 4'b1011.
- Gapped and back-to-back: send 1100 with en=0 gaps between bits → PO=4'b1100. Then send 0110 and 1001 back-to-back with po_ready=1 → PO=0110 then 1001, each valid in the cycle after its 4th bit, and no overrun.
- Overrun: send 1010 and leave it unread, then send 0101 → PO stays 1010 and overrun=1. Pulse ovr_clr → overrun=0. Check the simultaneous-completion case: accept on the same edge the 4th bit of 0101 arrives → PO=0101 and overrun stays 0.
- Abort: sof, 1, 1, then sof with SI=0, followed by 0,1,1 → abort pulses one cycle, PO=4'b0011, overrun=0. Bits sent before any sof are ignored.
- Reset mid-word and end-to-end: assert rst after 2 bits, then send a full word → PO reflects only the post-reset word. Chain the PISO serializer (PI=1011, en load pulse) into this block with sof on the load-following bit → PO=1011.
